csr_unit: RTL and testbench
===========================

// Module: csr_unit
// PURPOSE
//  Machine-mode CSR file and trap responder for the 3-stage RV32 pipeline. It executes the
//  CSR_reg_wr / CSR_reg_rd / is_mret commands produced by instruction decode.
//  It lives in the memory/writeback stage, holds the machine CSRs, and tracks a machine
//  timer interrupt line. It produces the PC redirect (epc_taken/excep_pc) for interrupt
//  entry and for MRET return.
// PARAMETERS
//  XLEN        32       data/address width (only 32 supported)
//  MTVEC_RST   32'h0    reset value of mtvec
//  CAUSE_MTI   31'd7    exception code written to mcause[30:0] on timer interrupt
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     asynchronous active-high reset
//  instr_valid  in   1     MW-stage instruction is real (0 = bubble/flushed)
//  pc           in   32    PC of MW-stage instruction
//  csr_reg_wr   in   1     CSR write command (CSRRW) from decode, pipelined to MW
//  csr_reg_rd   in   1     CSR read command from decode, pipelined to MW
//  is_mret      in   1     MRET command, pipelined to MW
//  csr_addr     in   12    CSR address (instruction[31:20])
//  csr_wdata    in   32    write data (rs1 value)
//  timer_irq    in   1     level-sensitive machine timer interrupt request
//  csr_rdata    out  32    read data of addressed CSR, to writeback mux (wb_sel=3)
//  epc_taken    out  1     redirect fetch to excep_pc and flush younger stages this cycle
//  excep_pc     out  32    redirect target
// BEHAVIOUR
//  Implemented CSRs (all other addresses read 0, writes ignored):
//   300 mstatus: bit3 MIE and bit7 MPIE are writable; all other bits read 0.
//   304 mie: bit7 MTIE is writable; all other bits read 0.
//   305 mtvec: bits[31:2] BASE and bit0 MODE are writable; bit1 reads 0.
//   341 mepc: bits[31:2] are writable; bits[1:0] read 0.
//   342 mcause: all bits writable.
//   344 mip: read-only; bit7 MTIP.
//   B00 mcycle: writable.
//  Reset: every CSR is 0, except mtvec = MTVEC_RST. Outputs are combinational on these, so
//   csr_rdata=0 (except when addressing mtvec) and epc_taken=0 throughout reset.
//  Reset asserted mid-operation clears all state immediately. No pending trap survives reset.
//  mip.MTIP <= timer_irq every cycle. This gives one cycle of latency from the pin.
//  mcycle increments by 1 every cycle and wraps from FFFFFFFF to 0.
//   A CSR write to mcycle in the same cycle takes precedence over the increment.
//  Read: csr_rdata = value of csr_addr, combinational, independent of csr_reg_rd.
//   It shows the pre-write (old) value, so CSRRW returns the old value. A write is visible
//   to a read in the next cycle.
//  irq_take = instr_valid & mstatus.MIE & mie.MTIE & mip.MTIP.
//  Priority each cycle: irq_take > is_mret > csr_reg_wr. Only one action is performed.
//   irq_take:
//    epc_taken=1.
//    excep_pc = {BASE,2'b00} when MODE=0; {BASE,2'b00} + 4*CAUSE_MTI when MODE=1.
//    Next edge: mepc<=pc; mcause<={1'b1,CAUSE_MTI}; MPIE<=MIE; MIE<=0.
//    The MW instruction is suppressed: its CSR write and MRET are dropped. It is re-executed
//    after return because mepc = its pc.
//   is_mret & instr_valid:
//    epc_taken=1; excep_pc=mepc.
//    Next edge: MIE<=MPIE; MPIE<=1.
//   csr_reg_wr & instr_valid: the write lands at the next edge, subject to the field masks.
//   Write to mstatus in the same cycle: MIE from the new value gates irq_take only from the
//    next cycle.
//  instr_valid=0: no CSR write, no mret, no trap. epc_taken=0; mcycle still counts.
// TESTING
//  1 Reset, then read every address -> mtvec=MTVEC_RST, others 0.
//    Read 0x7C0 -> 0; writing 0x7C0 has no effect.
//  2 CSRRW 0x305 <- 0x00001003, read back -> 0x00001001. Same-cycle csr_rdata shows the old
//    value.
//  3 mie=0x80, mstatus=0x8, mtvec=0x100. timer_irq=1 with pc=0x40 valid, 1 cycle later ->
//    epc_taken=1, excep_pc=0x100. Next: mepc=0x40, mcause=0x80000007, mstatus=0x80.
//  4 Same as 3 but mtvec=0x101 -> excep_pc=0x11C. A concurrent CSR write and is_mret are
//    dropped.
//  5 After trap, is_mret valid -> epc_taken=1, excep_pc=0x40. Next: mstatus=0x88.
//    With instr_valid=0 -> no redirect and no state change.
//  6 Write mcycle=0xFFFFFFFF -> next 0x0, then 0x1. Assert rst mid-trap -> all CSRs reset,
//    epc_taken=0.

Source files
------------

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file and timer-interrupt trap responder for the
// MW stage of the 3-stage RV32 pipeline.
//
// Ports
//   clk, rst            rising-edge clock, async active-high reset
//   instr_valid, pc     MW-stage instruction qualifier and its PC
//   csr_reg_wr          CSRRW write command
//   csr_reg_rd          CSR read command (read data is always driven)
//   is_mret             MRET command
//   csr_addr, csr_wdata CSR address / write data
//   timer_irq           level machine timer interrupt request
//   csr_rdata           combinational read of csr_addr (pre-write value)
//   epc_taken, excep_pc fetch redirect for trap entry / MRET return
module csr_unit #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] MTVEC_RST = 32'h0,
  parameter logic [30:0] CAUSE_MTI = 31'd7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc,
  input  logic            csr_reg_wr,
  input  logic            csr_reg_rd,
  input  logic            is_mret,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            timer_irq,
  output logic [XLEN-1:0] csr_rdata,
  output logic            epc_taken,
  output logic [XLEN-1:0] excep_pc
);
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;
  localparam logic [11:0] A_MCYCLE  = 12'hB00;

  // Only the architected bits are stored; everything else reads as 0.
  logic            st_mie, st_mpie;
  logic            mie_mtie;
  logic            mip_mtip;
  logic [XLEN-1:2] mtvec_base;
  logic            mtvec_mode;
  logic [XLEN-1:2] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mcycle;

  logic irq_take, mret_take, wr_take;

  // Reset gating keeps the redirect quiet while rst is held, even if the
  // pipeline presents a valid MRET.
  assign irq_take  = ~rst & instr_valid & st_mie & mie_mtie & mip_mtip;
  assign mret_take = ~rst & instr_valid & is_mret & ~irq_take;
  assign wr_take   = ~rst & instr_valid & csr_reg_wr & ~irq_take & ~is_mret;

  assign epc_taken = irq_take | mret_take;

  always_comb begin
    excep_pc = '0;
    if (irq_take) begin
      // Vectored mode: BASE + 4*cause.
      excep_pc = {mtvec_base, 2'b00};
      if (mtvec_mode)
        excep_pc = {mtvec_base, 2'b00} + {CAUSE_MTI[XLEN-3:0], 2'b00};
    end else if (mret_take) begin
      excep_pc = {mepc, 2'b00};
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      A_MSTATUS: begin
        csr_rdata[3] = st_mie;
        csr_rdata[7] = st_mpie;
      end
      A_MIE:    csr_rdata[7] = mie_mtie;
      A_MTVEC:  csr_rdata = {mtvec_base, 1'b0, mtvec_mode};
      A_MEPC:   csr_rdata = {mepc, 2'b00};
      A_MCAUSE: csr_rdata = mcause;
      A_MIP:    csr_rdata[7] = mip_mtip;
      A_MCYCLE: csr_rdata = mcycle;
      default:  csr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_mtie   <= 1'b0;
      mip_mtip   <= 1'b0;
      mtvec_base <= MTVEC_RST[XLEN-1:2];
      mtvec_mode <= MTVEC_RST[0];
      mepc       <= '0;
      mcause     <= '0;
      mcycle     <= '0;
    end else begin
      mip_mtip <= timer_irq;

      if (wr_take && csr_addr == A_MCYCLE) mcycle <= csr_wdata;
      else                                 mcycle <= mcycle + XLEN'(1);

      if (irq_take) begin
        // The MW instruction is abandoned; mepc points back at it.
        mepc    <= pc[XLEN-1:2];
        mcause  <= {1'b1, CAUSE_MTI};
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (mret_take) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (wr_take) begin
        case (csr_addr)
          A_MSTATUS: begin
            st_mie  <= csr_wdata[3];
            st_mpie <= csr_wdata[7];
          end
          A_MIE:    mie_mtie <= csr_wdata[7];
          A_MTVEC: begin
            mtvec_base <= csr_wdata[XLEN-1:2];
            mtvec_mode <= csr_wdata[0];
          end
          A_MEPC:   mepc   <= csr_wdata[XLEN-1:2];
          A_MCAUSE: mcause <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

  // Read data is driven regardless of the read command; low PC bits are
  // never stored because mepc is word aligned.
  logic unused_ok;
  assign unused_ok = ^{csr_reg_rd, pc[1:0], CAUSE_MTI[30:XLEN-2]};
endmodule

// File: tb/tb_csr_unit.sv
module tb_csr_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] pc;
  logic        csr_reg_wr, csr_reg_rd, is_mret;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        timer_irq;
  logic [31:0] csr_rdata;
  logic        epc_taken;
  logic [31:0] excep_pc;

  csr_unit #(.XLEN(32), .MTVEC_RST(32'h0000_0200), .CAUSE_MTI(31'd7)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc(pc),
    .csr_reg_wr(csr_reg_wr), .csr_reg_rd(csr_reg_rd), .is_mret(is_mret),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .timer_irq(timer_irq),
    .csr_rdata(csr_rdata), .epc_taken(epc_taken), .excep_pc(excep_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          chk_rd;
    logic [31:0] rd;
    bit          epc;
    logic [31:0] xpc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Monitor: outputs are combinational, so each cycle that stimulus tagged
  // with an expectation is checked mid-cycle on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.chk_rd) begin
        checks++;
        if (csr_rdata !== e.rd) begin
          errors++;
          $display("FAIL %s: csr_rdata=%h expected %h", e.name, csr_rdata, e.rd);
        end
      end
      checks++;
      if (epc_taken !== e.epc || (e.epc && excep_pc !== e.xpc)) begin
        errors++;
        $display("FAIL %s: epc_taken=%b excep_pc=%h expected %b/%h",
                 e.name, epc_taken, excep_pc, e.epc, e.xpc);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    instr_valid = 0; csr_reg_wr = 0; csr_reg_rd = 0; is_mret = 0;
    csr_wdata = 0;
  endtask

  task automatic expect_rd(input string nm, input logic [31:0] v);
    exp_t e;
    e.name = nm; e.chk_rd = 1; e.rd = v; e.epc = 0; e.xpc = 0;
    sb.push_back(e);
  endtask

  task automatic expect_epc(input string nm, input bit chk_rd, input logic [31:0] v,
                            input bit epc, input logic [31:0] xpc);
    exp_t e;
    e.name = nm; e.chk_rd = chk_rd; e.rd = v; e.epc = epc; e.xpc = xpc;
    sb.push_back(e);
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] v);
    clr(); csr_reg_rd = 1; instr_valid = 1; csr_addr = a;
    expect_rd(nm, v);
    tick();
    clr();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    clr(); instr_valid = 1; csr_reg_wr = 1; csr_addr = a; csr_wdata = d;
    tick();
    clr();
  endtask

  initial begin
    rst = 1; clr(); pc = 0; csr_addr = 0; timer_irq = 0;
    tick();

    // Held in reset: valid MRET must not redirect; mtvec shows its reset value.
    instr_valid = 1; is_mret = 1; csr_addr = 12'h305;
    expect_rd("rst_mtvec", 32'h200);
    tick();
    csr_addr = 12'h300; expect_rd("rst_mstatus", 0);
    tick();
    rst = 0; clr();

    rd("mcycle0", 12'hB00, 0);
    rd("mcycle1", 12'hB00, 1);
    rd("mstatus0", 12'h300, 0);
    rd("mie0", 12'h304, 0);
    rd("mepc0", 12'h341, 0);
    rd("mcause0", 12'h342, 0);
    rd("mip0", 12'h344, 0);
    rd("mtvec0", 12'h305, 32'h200);
    rd("unimpl0", 12'h7C0, 0);
    wr(12'h7C0, 32'hDEADBEEF);
    rd("unimpl_wr", 12'h7C0, 0);

    // mip follows timer_irq with one cycle of latency.
    timer_irq = 1; csr_addr = 12'h344; expect_rd("mip_lat", 0); tick();
    csr_addr = 12'h344; expect_rd("mip_set", 32'h80); tick();
    timer_irq = 0; tick();

    wr(12'h300, 32'hFFFFFFFF); rd("mstatus_mask", 12'h300, 32'h88);
    wr(12'h304, 32'hFFFFFFFF); rd("mie_mask", 12'h304, 32'h80);
    wr(12'h341, 32'hFFFFFFFF); rd("mepc_mask", 12'h341, 32'hFFFFFFFC);
    wr(12'h342, 32'h12345678); rd("mcause_wr", 12'h342, 32'h12345678);
    wr(12'h344, 32'h0);        rd("mip_ro", 12'h344, 0);

    // CSRRW returns the old value in the writing cycle.
    clr(); instr_valid = 1; csr_reg_wr = 1; csr_addr = 12'h305; csr_wdata = 32'h1003;
    expect_rd("mtvec_old", 32'h200); tick(); clr();
    rd("mtvec_new", 12'h305, 32'h1001);

    // Direct-mode interrupt entry.
    wr(12'h305, 32'h100); wr(12'h300, 32'h8);
    timer_irq = 1; instr_valid = 1; pc = 32'h40;
    expect_epc("irq_lat", 0, 0, 0, 0); tick();
    instr_valid = 1; expect_epc("irq_direct", 0, 0, 1, 32'h100); tick();
    timer_irq = 0; clr();
    rd("trap_mepc", 12'h341, 32'h40);
    rd("trap_mcause", 12'h342, 32'h80000007);
    rd("trap_mstatus", 12'h300, 32'h80);

    // MRET on a bubble (with a stray write) does nothing.
    clr(); is_mret = 1; csr_reg_wr = 1; csr_addr = 12'h300; csr_wdata = 0;
    expect_epc("mret_bubble", 1, 32'h80, 0, 0); tick(); clr();
    rd("mret_bubble_st", 12'h300, 32'h80);
    clr(); instr_valid = 1; is_mret = 1; csr_addr = 12'h300;
    expect_epc("mret_take", 1, 32'h80, 1, 32'h40); tick(); clr();
    rd("mret_mstatus", 12'h300, 32'h88);

    // Vectored-mode entry; concurrent write and MRET are dropped.
    wr(12'h305, 32'h101); rd("mtvec_vec", 12'h305, 32'h101);
    timer_irq = 1; instr_valid = 1; pc = 32'h44;
    expect_epc("irq_lat2", 0, 0, 0, 0); tick();
    instr_valid = 1; csr_reg_wr = 1; is_mret = 1; csr_addr = 12'h304; csr_wdata = 0;
    expect_epc("irq_vec", 1, 32'h80, 1, 32'h11C); tick();
    timer_irq = 0; clr();
    rd("drop_wr", 12'h304, 32'h80);
    rd("vec_mepc", 12'h341, 32'h44);
    rd("drop_mret", 12'h300, 32'h80);

    // mcycle write then wrap.
    wr(12'hB00, 32'hFFFFFFFF);
    rd("mcycle_wr", 12'hB00, 32'hFFFFFFFF);
    rd("mcycle_wrap", 12'hB00, 0);
    rd("mcycle_inc", 12'hB00, 1);

    // Reset while a trap is being presented.
    wr(12'h300, 32'h8);
    timer_irq = 1; instr_valid = 1; pc = 32'h48;
    expect_epc("irq_lat3", 0, 0, 0, 0); tick();
    instr_valid = 1; expect_epc("irq_pre_rst", 0, 0, 1, 32'h11C);
    @(negedge clk); #1 rst = 1;
    tick();
    csr_addr = 12'h341; expect_epc("rst_mid_trap", 1, 0, 0, 0); tick();
    rst = 0; timer_irq = 0; clr();
    rd("rst_mstatus2", 12'h300, 0);
    rd("rst_mepc2", 12'h341, 0);
    rd("rst_mcause2", 12'h342, 0);
    rd("rst_mie2", 12'h304, 0);
    rd("rst_mtvec2", 12'h305, 32'h200);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
